// File: rtl/board_drop_ctrl.sv
// Connect-4 gravity-drop controller: move check, optional fall, board commit.
// Define BOARD_DROP_ANIM_EN to build the FALL animation state and tick counter.
module board_drop_ctrl #(
  parameter int ROWS       = 6,
  parameter int COLS       = 7,
  parameter int FALL_TICKS = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       valid_move,
  input  logic [2:0] selected_col,
  output logic       busy,
  output logic       move_done,
  output logic       move_reject,
  output logic [2:0] placed_row,
  output logic [2:0] placed_col,
  output logic       placed_player,
  output logic       turn,
  output logic       anim_active,
  output logic [2:0] anim_row,
  output logic [5:0] move_count,
  output logic       board_full,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FALL,
    COMMIT
  } state_t;

  localparam int CELLS = ROWS * COLS;

  state_t     state;
  logic [1:0] cells [ROWS][COLS];
  logic [2:0] height [COLS];
  logic [2:0] col;
  logic [2:0] target;
  logic [2:0] cur_h;
  logic       col_ok;

`ifdef BOARD_DROP_ANIM_EN
  localparam int TW = $clog2(FALL_TICKS + 1);
  logic [TW-1:0] tick;
`else
  assign anim_active = 1'b0;
  assign anim_row    = 3'd0;
`endif

  // An out-of-range column reads as full so CHECK rejects it.
  always_comb begin
    col_ok = 32'(col) < COLS;
    cur_h  = 3'(ROWS);
    if (col_ok) cur_h = height[col];
  end

  assign busy       = state != IDLE;
  assign board_full = move_count == 6'(CELLS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      col           <= 3'd0;
      target        <= 3'd0;
      move_done     <= 1'b0;
      move_reject   <= 1'b0;
      placed_row    <= 3'd0;
      placed_col    <= 3'd0;
      placed_player <= 1'b0;
      turn          <= 1'b0;
      move_count    <= 6'd0;
      for (int c = 0; c < COLS; c++) begin
        height[c] <= 3'd0;
        for (int r = 0; r < ROWS; r++)
          cells[r][c] <= 2'b00;
      end
`ifdef BOARD_DROP_ANIM_EN
      tick        <= '0;
      anim_active <= 1'b0;
      anim_row    <= 3'd0;
`endif
    end else if (new_game) begin
      state         <= IDLE;
      col           <= 3'd0;
      target        <= 3'd0;
      move_done     <= 1'b0;
      move_reject   <= 1'b0;
      placed_row    <= 3'd0;
      placed_col    <= 3'd0;
      placed_player <= 1'b0;
      turn          <= 1'b0;
      move_count    <= 6'd0;
      for (int c = 0; c < COLS; c++) begin
        height[c] <= 3'd0;
        for (int r = 0; r < ROWS; r++)
          cells[r][c] <= 2'b00;
      end
`ifdef BOARD_DROP_ANIM_EN
      tick        <= '0;
      anim_active <= 1'b0;
      anim_row    <= 3'd0;
`endif
    end else begin
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_move) begin
            col   <= selected_col;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!col_ok || cur_h == 3'(ROWS) || board_full) begin
            move_reject <= 1'b1;
            state       <= IDLE;
          end else begin
            target <= cur_h;
`ifdef BOARD_DROP_ANIM_EN
            anim_row    <= 3'(ROWS - 1);
            anim_active <= 1'b1;
            tick        <= '0;
            state       <= FALL;
`else
            state <= COMMIT;
`endif
          end
        end
        FALL: begin
`ifdef BOARD_DROP_ANIM_EN
          if (tick == TW'(FALL_TICKS - 1)) begin
            tick <= '0;
            if (anim_row == target) begin
              anim_active <= 1'b0;
              state       <= COMMIT;
            end else begin
              anim_row <= anim_row - 3'd1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
`else
          state <= IDLE;
`endif
        end
        COMMIT: begin
          cells[target][col] <= turn ? 2'b10 : 2'b01;
          height[col]        <= height[col] + 3'd1;
          move_count         <= move_count + 6'd1;
          placed_row         <= target;
          placed_col         <= col;
          placed_player      <= turn;
          move_done          <= 1'b1;
          turn               <= ~turn;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Renderer port: same-edge writes are seen on the following read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_cell <= 2'b00;
    else if (32'(rd_row) < ROWS && 32'(rd_col) < COLS)
      rd_cell <= cells[rd_row][rd_col];
    else
      rd_cell <= 2'b00;
  end

endmodule

// File: tb/tb_board_drop_ctrl.sv
// Scoreboard bench for board_drop_ctrl; FALL_TICKS shortened to 4.
// Animation scenarios run only when BOARD_DROP_ANIM_EN is defined.
module tb_board_drop_ctrl;

  localparam int FT = 4;
`ifdef BOARD_DROP_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0;
  logic       valid_move = 1'b0;
  logic [2:0] selected_col = 3'd0;
  logic       busy, move_done, move_reject;
  logic [2:0] placed_row, placed_col;
  logic       placed_player, turn, anim_active;
  logic [2:0] anim_row;
  logic [5:0] move_count;
  logic       board_full;
  logic [2:0] rd_row = 3'd0;
  logic [2:0] rd_col = 3'd0;
  logic [1:0] rd_cell;

  board_drop_ctrl #(.ROWS(6), .COLS(7), .FALL_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .valid_move(valid_move), .selected_col(selected_col),
    .busy(busy), .move_done(move_done), .move_reject(move_reject),
    .placed_row(placed_row), .placed_col(placed_col),
    .placed_player(placed_player), .turn(turn),
    .anim_active(anim_active), .anim_row(anim_row),
    .move_count(move_count), .board_full(board_full),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rej;
    logic [2:0] row;
    logic [2:0] col;
    logic       pl;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   mh[7];
  logic mturn;
  int   mcount;
  int   checks = 0;
  int   failures = 0;

  function automatic int acc_lat(input int row);
    return ANIM ? 3 + (6 - row) * FT : 3;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 7; c++) mh[c] = 0;
    mturn  = 1'b0;
    mcount = 0;
    sb.delete();
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic read_cell(input int r, input int c, output logic [1:0] v);
    @(negedge clk);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(negedge clk);
    v = rd_cell;
  endtask

  // Drive one move, push its prediction, then pop and compare at the pulse.
  task automatic run_move(input logic [2:0] c);
    exp_t e, got;
    int   n;
    logic acc;
    acc   = (c < 3'd7) && (mh[c] < 6) && (mcount < 42);
    e.rej = !acc;
    e.col = c;
    e.pl  = mturn;
    e.row = acc ? 3'(mh[c]) : 3'd0;
    e.lat = acc ? acc_lat(mh[c]) : 2;
    sb.push_back(e);
    @(negedge clk);
    valid_move   = 1'b1;
    selected_col = c;
    @(negedge clk);
    valid_move = 1'b0;
    n = 1;
    while (!(move_done || move_reject) && n < 200) begin
      @(negedge clk);
      n++;
    end
    got = sb.pop_front();
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL move_timeout col=%0d got no pulse need pulse", c);
      return;
    end
    checks++;
    if (move_reject !== got.rej) begin
      failures++;
      $display("FAIL move_reject col=%0d got %b need %b", c, move_reject, got.rej);
    end
    checks++;
    if (n !== got.lat) begin
      failures++;
      $display("FAIL move_latency col=%0d got %0d need %0d", c, n, got.lat);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_pulse col=%0d got %b need 0", c, busy);
    end
    if (acc) begin
      mh[c]++;
      mturn = ~mturn;
      mcount++;
      checks++;
      if (placed_row !== got.row || placed_col !== got.col
          || placed_player !== got.pl) begin
        failures++;
        $display("FAIL placed col=%0d got r%0d c%0d p%0d need r%0d c%0d p%0d",
                 c, placed_row, placed_col, placed_player, got.row, got.col, got.pl);
      end
    end
    checks++;
    if (turn !== mturn || move_count !== 6'(mcount)) begin
      failures++;
      $display("FAIL turn_count col=%0d got t%b n%0d need t%b n%0d",
               c, turn, move_count, mturn, mcount);
    end
  endtask

  task automatic test_reset();
    logic [1:0] v;
    int bad;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, move_done, move_reject, placed_row, placed_col, placed_player,
         turn, anim_active, anim_row, move_count, board_full, rd_cell} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy%b done%b rej%b turn%b cnt%0d need all 0",
               busy, move_done, move_reject, turn, move_count);
    end
    rst = 1'b1;
    model_clear();
    bad = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        read_cell(r, c, v);
        if (v !== 2'b00) bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_cells got %0d nonempty need 0", bad);
    end
    read_cell(7, 7, v);
    checks++;
    if (v !== 2'b00) begin
      failures++;
      $display("FAIL read_out_of_range got %b need 00", v);
    end
  endtask

  task automatic test_single();
    logic [1:0] v;
    do_new_game();
    run_move(3'd4);
    read_cell(0, 4, v);
    checks++;
    if (v !== 2'b01) begin
      failures++;
      $display("FAIL single_cell got %b need 01", v);
    end
  endtask

  task automatic test_column_fill();
    logic [1:0] v;
    do_new_game();
    for (int i = 0; i < 7; i++) run_move(3'd6);
    for (int r = 0; r < 6; r++) begin
      read_cell(r, 6, v);
      checks++;
      if (v !== ((r % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL col_fill r%0d got %b need %b", r, v,
                 (r % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
  endtask

  task automatic test_illegal_and_busy();
    logic [1:0] v;
    exp_t e;
    int n, extra;
    do_new_game();
    run_move(3'd7);
    // A second request while busy must be dropped silently.
    e.rej = 1'b0; e.col = 3'd0; e.row = 3'd0; e.pl = mturn; e.lat = acc_lat(0);
    sb.push_back(e);
    @(negedge clk);
    valid_move = 1'b1;
    selected_col = 3'd0;
    @(negedge clk);
    selected_col = 3'd1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_request got %b need 1", busy);
    end
    @(negedge clk);
    valid_move = 1'b0;
    n = 2;
    while (!(move_done || move_reject) && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (!move_done || n !== e.lat || placed_col !== e.col) begin
      failures++;
      $display("FAIL busy_first_move got done%b lat%0d c%0d need done1 lat%0d c%0d",
               move_done, n, placed_col, e.lat, e.col);
    end
    mh[0]++; mturn = ~mturn; mcount++;
    extra = 0;
    repeat (ANIM ? 40 : 8) begin
      @(negedge clk);
      if (move_done || move_reject || busy) extra++;
    end
    checks++;
    if (extra != 0 || move_count !== 6'(mcount)) begin
      failures++;
      $display("FAIL busy_ignored got %0d extra cnt%0d need 0 cnt%0d",
               extra, move_count, mcount);
    end
    read_cell(0, 1, v);
    checks++;
    if (v !== 2'b00) begin
      failures++;
      $display("FAIL busy_ignored_cell got %b need 00", v);
    end
  endtask

  task automatic test_same_edge_read();
    logic [1:0] seen_at, seen_after;
    int n;
    do_new_game();
    @(negedge clk);
    rd_row = 3'd0;
    rd_col = 3'd3;
    valid_move = 1'b1;
    selected_col = 3'd3;
    @(negedge clk);
    valid_move = 1'b0;
    n = 1;
    while (!move_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    seen_at = rd_cell;
    @(negedge clk);
    seen_after = rd_cell;
    mh[3]++; mturn = ~mturn; mcount++;
    checks++;
    if (n >= 200 || seen_at !== 2'b00 || seen_after !== 2'b01) begin
      failures++;
      $display("FAIL same_edge_read got %b then %b need 00 then 01",
               seen_at, seen_after);
    end
  endtask

  task automatic test_new_game_drop();
    int hits;
    run_move(3'd5);
    @(negedge clk);
    new_game = 1'b1;
    valid_move = 1'b1;
    selected_col = 3'd2;
    @(negedge clk);
    new_game = 1'b0;
    valid_move = 1'b0;
    model_clear();
    hits = 0;
    repeat (5) begin
      if (busy || move_done || move_reject) hits++;
      @(negedge clk);
    end
    checks++;
    if (hits != 0 || move_count !== 6'd0 || turn !== 1'b0) begin
      failures++;
      $display("FAIL new_game_drop got %0d hits cnt%0d turn%b need 0 0 0",
               hits, move_count, turn);
    end
  endtask

  task automatic test_anim();
    logic [1:0] v;
    int n, bad, dones;
    do_new_game();
    @(negedge clk);
    valid_move = 1'b1;
    selected_col = 3'd2;
    @(negedge clk);
    valid_move = 1'b0;
    n = 1;
    bad = 0;
    while (!move_done && n < 200) begin
      if (n >= 2 && n <= 25)
        if (anim_active !== 1'b1 || anim_row !== 3'(5 - (n - 2) / 4)) bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL anim_rows got %0d bad cycles need 0", bad);
    end
    checks++;
    if (n !== 27 || anim_active !== 1'b0) begin
      failures++;
      $display("FAIL anim_latency got %0d need 27", n);
    end
    mh[2]++; mturn = ~mturn; mcount++;
    @(negedge clk);
    valid_move = 1'b1;
    selected_col = 3'd0;
    @(negedge clk);
    valid_move = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (anim_active !== 1'b1) begin
      failures++;
      $display("FAIL anim_in_fall got %b need 1", anim_active);
    end
    do_new_game();
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (move_done) dones++;
    end
    checks++;
    if (dones != 0 || turn !== 1'b0 || move_count !== 6'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL anim_abort got done%0d turn%b cnt%0d need 0 0 0",
               dones, turn, move_count);
    end
    read_cell(0, 2, v);
    checks++;
    if (v !== 2'b00) begin
      failures++;
      $display("FAIL anim_abort_cell got %b need 00", v);
    end
  endtask

  task automatic test_board_full();
    do_new_game();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        run_move(3'(c));
    checks++;
    if (board_full !== 1'b1 || move_count !== 6'd42) begin
      failures++;
      $display("FAIL board_full got f%b cnt%0d need f1 cnt42", board_full, move_count);
    end
    run_move(3'd3);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_column_fill();
    test_illegal_and_busy();
    test_same_edge_read();
    test_new_game_drop();
    if (ANIM) test_anim();
    test_board_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
